// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared types for the instruction register and its read-side
//               execution unit: opcodes, operands, entry addresses, the
//               packed instruction word and the signed execution result.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

  // Depth of the instruction register; entry addresses are log2 of this.
  localparam int REG_DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0]                  operand_t;
  typedef logic        [$clog2(REG_DEPTH)-1:0] address_t;
  typedef logic signed [63:0]                  result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage
`default_nettype wire

// File: rtl/instr_alu.sv
`default_nettype none
// ============================================================================
// Module      : instr_alu
// Description : Purely combinational execution of one instruction word.
//               Operands are sign-extended to 64 bits before the operation.
// Ports       : instr       - instruction word (opcode, op_a, op_b)
//               result      - signed 64-bit result
//               div_by_zero - DIV/MOD attempted with op_b == 0
// Revision    : 1.0 - initial release
// ============================================================================
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      result,
  output logic         div_by_zero
);

  result_t w_a;
  result_t w_b;

  always_comb begin
    w_a         = {{32{instr.op_a[31]}}, instr.op_a};
    w_b         = {{32{instr.op_b[31]}}, instr.op_b};
    result      = '0;
    div_by_zero = 1'b0;
    case (instr.opc)
      ZERO:  result = '0;
      PASSA: result = w_a;
      PASSB: result = w_b;
      ADD:   result = w_a + w_b;
      SUB:   result = w_a - w_b;
      // 64x64 keeps the full product of two sign-extended 32-bit operands.
      MULT:  result = w_a * w_b;
      // Signed / and % truncate toward zero, so the remainder takes the
      // dividend's sign. At 64 bits, MIN/-1 cannot overflow.
      DIV: begin
        if (w_b == '0) div_by_zero = 1'b1;
        else           result      = w_a / w_b;
      end
      MOD: begin
        if (w_b == '0) div_by_zero = 1'b1;
        else           result      = w_a % w_b;
      end
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_exec.sv
`default_nettype none
// ============================================================================
// Module      : instr_exec
// Description : Read-side consumer of the instruction register. A start
//               request walks read_pointer across a run of entries. Each
//               entry is fetched, executed and returned as one result over a
//               valid/ready handshake.
// Ports       : clk, reset           - clock, async active-high reset
//               start, first_ptr,    - run request (sampled only when idle)
//               count
//               read_pointer,        - register read port
//               instruction_word
//               res_valid/res_ready  - result handshake
//               result, res_opcode,  - result and its tags
//               res_index, div_by_zero
//               busy, done           - status, done is a one-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
module instr_exec
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = REG_DEPTH,
  parameter int RES_W       = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  address_t                first_ptr,
  input  logic [5:0]              count,
  output address_t                read_pointer,
  input  instruction_t            instruction_word,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [RES_W-1:0] result,
  output opcode_t                 res_opcode,
  output address_t                res_index,
  output logic                    div_by_zero,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [5:0] C_MAX_COUNT = 6'(NUM_ENTRIES);

  state_t                    r_state;
  state_t                    w_state_next;
  address_t                  r_ptr;
  address_t                  r_fetch_ptr;
  logic [5:0]                r_remaining;
  instruction_t              r_instr;
  logic signed [RES_W-1:0]   r_result;
  opcode_t                   r_res_opcode;
  address_t                  r_res_index;
  logic                      r_div_by_zero;
  logic                      r_done;

  result_t                   w_alu_result;
  logic                      w_alu_dbz;
  logic                      w_start_run;
  logic                      w_start_empty;
  logic                      w_handshake;
  logic                      w_last;

  assign w_start_run   = (r_state == S_IDLE) && start && (count != 6'd0);
  assign w_start_empty = (r_state == S_IDLE) && start && (count == 6'd0);
  assign w_handshake   = (r_state == S_HOLD) && res_ready;
  assign w_last        = (r_remaining == 6'd1);

  instr_alu u_alu (
    .instr       (r_instr),
    .result      (w_alu_result),
    .div_by_zero (w_alu_dbz)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_run) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_HOLD;
      S_HOLD:  if (res_ready) w_state_next = w_last ? S_IDLE : S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointer, run length, fetch and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr         <= '0;
      r_fetch_ptr   <= '0;
      r_remaining   <= '0;
      r_instr       <= '0;
      r_result      <= '0;
      r_res_opcode  <= ZERO;
      r_res_index   <= '0;
      r_div_by_zero <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_start_empty || (w_handshake && w_last);

      if (w_start_run) begin
        r_ptr       <= first_ptr;
        r_remaining <= (count > C_MAX_COUNT) ? C_MAX_COUNT : count;
      end else if (w_handshake) begin
        // Address width equals log2 of the depth, so +1 wraps 31 -> 0.
        r_ptr       <= r_ptr + 1'b1;
        r_remaining <= r_remaining - 6'd1;
      end

      if (r_state == S_FETCH) begin
        r_instr     <= instruction_word;
        r_fetch_ptr <= r_ptr;
      end

      // Result registers load only in EXEC, so they hold through HOLD.
      if (r_state == S_EXEC) begin
        r_result      <= RES_W'(w_alu_result);
        r_res_opcode  <= r_instr.opc;
        r_res_index   <= r_fetch_ptr;
        r_div_by_zero <= w_alu_dbz;
      end
    end
  end

  assign read_pointer = r_ptr;
  assign res_valid    = (r_state == S_HOLD);
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign result       = r_result;
  assign res_opcode   = r_res_opcode;
  assign res_index    = r_res_index;
  assign div_by_zero  = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_instr_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_exec
// Description : Self-checking bench for instr_exec. A behavioural register
//               array feeds instruction_word. Expected results come from a
//               hand-computed vector table and from an arithmetic reference
//               model applied to randomized runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_exec;
  import instr_register_pkg::*;

  logic               clk;
  logic               reset;
  logic               start;
  address_t           first_ptr;
  logic [5:0]         count;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] result;
  opcode_t            res_opcode;
  address_t           res_index;
  logic               div_by_zero;
  logic               busy;
  logic               done;

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  instr_exec #(.NUM_ENTRIES(32), .RES_W(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_ptr        (first_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .result           (result),
    .res_opcode       (res_opcode),
    .res_index        (res_index),
    .div_by_zero      (div_by_zero),
    .busy             (busy),
    .done             (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  longint obs_res [$];
  bit     obs_dbz [$];
  int     obs_idx [$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the arithmetic rules applied to 64-bit signed integers.
  function automatic longint ref_alu(input instruction_t ins, output bit dbz);
    longint a;
    longint b;
    a   = ins.op_a;
    b   = ins.op_b;
    dbz = 1'b0;
    case (ins.opc)
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      DIV:     begin if (b == 0) begin dbz = 1'b1; return 0; end return a / b; end
      MOD:     begin if (b == 0) begin dbz = 1'b1; return 0; end return a % b; end
      default: return 0;
    endcase
  endfunction

  function automatic operand_t rand_operand();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return operand_t'($urandom_range(0, 40)) - 20;
      default: return operand_t'($urandom);
    endcase
  endfunction

  function automatic bit rand_ready(input int pct);
    return ($urandom_range(1, 100) <= pct);
  endfunction

  // Runs one request and checks every result against the reference model,
  // including latency after start/handshake, stability while stalled and the
  // done pulse. Observed results are queued for table comparisons.
  task automatic do_run(input int first, input int cnt, input int ready_pct);
    int     n_exp;
    int     k;
    int     gap;
    int     cyc;
    bit     waiting;
    bit     expect_done;
    int     exp_i;
    longint exp_r;
    bit     exp_d;
    n_exp = (cnt > 32) ? 32 : cnt;
    obs_res.delete(); obs_dbz.delete(); obs_idx.delete();
    first_ptr = address_t'(first);
    count     = 6'(cnt);
    start     = 1'b1;
    res_ready = rand_ready(ready_pct);
    @(negedge clk);
    start       = 1'b0;
    k           = 0;
    gap         = 1;
    cyc         = 0;
    waiting     = 1'b1;
    expect_done = (n_exp == 0);
    while (1) begin
      cyc++;
      if (cyc > 3000) begin
        check("run_timeout", 1, 0);
        break;
      end
      if (expect_done) begin
        check("run_done_pulse", {busy, done, res_valid}, 3'b010);
        break;
      end
      check("run_busy_no_done", {busy, done}, 2'b10);
      if (waiting && gap == 3) check("run_latency_valid", res_valid, 1);
      if (res_valid) begin
        exp_i = (first + k) % 32;
        exp_r = ref_alu(mem[exp_i], exp_d);
        if (waiting) begin
          waiting = 1'b0;
          obs_res.push_back(result);
          obs_dbz.push_back(div_by_zero);
          obs_idx.push_back(int'(res_index));
        end
        check("run_result", result, exp_r);
        check("run_dbz", div_by_zero, exp_d);
        check("run_index", res_index, exp_i);
        check("run_opcode", res_opcode, mem[exp_i].opc);
        check("run_read_pointer", read_pointer, exp_i);
        res_ready = rand_ready(ready_pct);
        if (res_ready) begin
          k++;
          gap     = 0;
          waiting = 1'b1;
          if (k == n_exp) expect_done = 1'b1;
        end
      end else begin
        if (!waiting) begin
          check("run_valid_dropped", res_valid, 1);
          break;
        end
        res_ready = rand_ready(ready_pct);
      end
      @(negedge clk);
      gap++;
    end
  endtask

  typedef struct {
    opcode_t opc;
    int      a;
    int      b;
    longint  exp_r;
    bit      exp_d;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    first_ptr = '0;
    count     = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {read_pointer, res_valid, result, res_opcode, res_index, div_by_zero, busy, done},
          '0);
    reset = 1'b0;
    @(negedge clk);

    // ---------------- ADD 5,7 single entry, exact timing ----------------
    mem[0] = '{opc: ADD, op_a: 5, op_b: 7};
    res_ready = 1'b1; first_ptr = 0; count = 6'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;                       // N+1 FETCH
    check("add_n1_flags", {busy, res_valid, done}, 3'b100);
    @(negedge clk);                                     // N+2 EXEC
    check("add_n2_valid", res_valid, 0);
    @(negedge clk);                                     // N+3 HOLD
    check("add_n3_valid", res_valid, 1);
    check("add_result", result, 12);
    check("add_index", res_index, 0);
    check("add_opcode", res_opcode, ADD);
    @(negedge clk);                                     // N+4
    check("add_done_pulse", {done, busy, res_valid}, 3'b100);
    @(negedge clk);
    check("add_done_clears", done, 0);

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{ADD,   5,  7,  12, 0};
    tbl[1]  = '{SUB,   3,  10, -7, 0};
    tbl[2]  = '{MULT, -3,  4,  -12, 0};
    tbl[3]  = '{MULT, 32'h7fffffff, 32'h7fffffff, 64'sd4611686014132420609, 0};
    tbl[4]  = '{DIV,  -7,  2,  -3, 0};
    tbl[5]  = '{MOD,  -7,  2,  -1, 0};
    tbl[6]  = '{MOD,   7, -2,   1, 0};
    tbl[7]  = '{DIV,  int'(32'h80000000), -1, 64'sd2147483648, 0};
    tbl[8]  = '{DIV,   9,  0,   0, 1};
    tbl[9]  = '{MOD,  -7,  3,  -1, 0};
    tbl[10] = '{opcode_t'(4'hB), 5, 5, 0, 0};
    tbl[11] = '{PASSA, 100, 200, 100, 0};
    tbl[12] = '{PASSB, 100, 200, 200, 0};
    tbl[13] = '{ZERO,  9,  9,   0, 0};
    tbl[14] = '{ADD,  int'(32'h80000000), -1, -64'sd2147483649, 0};
    for (int i = 0; i < 15; i++)
      mem[i] = '{opc: tbl[i].opc, op_a: tbl[i].a, op_b: tbl[i].b};
    do_run(0, 15, 60);
    check("tbl_count", obs_res.size(), 15);
    if (obs_res.size() == 15) begin
      for (int i = 0; i < 15; i++) begin
        check($sformatf("tbl_result_%0d", i), obs_res[i], tbl[i].exp_r);
        check($sformatf("tbl_dbz_%0d", i), obs_dbz[i], tbl[i].exp_d);
      end
    end

    // ---------------- DIV 9,0 then MOD -7,3 at entries 3..4 ----------------
    mem[3] = '{opc: DIV, op_a: 9,  op_b: 0};
    mem[4] = '{opc: MOD, op_a: -7, op_b: 3};
    do_run(3, 2, 100);
    check("dz_count", obs_res.size(), 2);
    if (obs_res.size() == 2) begin
      check("dz_res0", obs_res[0], 0);
      check("dz_flag0", obs_dbz[0], 1);
      check("dz_res1", obs_res[1], -1);
      check("dz_flag1", obs_dbz[1], 0);
    end

    // ---------------- pointer wrap 30,31,0,1 ----------------
    do_run(30, 4, 100);
    check("wrap_count", obs_idx.size(), 4);
    if (obs_idx.size() == 4) begin
      check("wrap_idx0", obs_idx[0], 30);
      check("wrap_idx1", obs_idx[1], 31);
      check("wrap_idx2", obs_idx[2], 0);
      check("wrap_idx3", obs_idx[3], 1);
    end

    // ---------------- stalled MULT, start ignored while busy ----------------
    mem[10] = '{opc: MULT, op_a: -3, op_b: 4};
    mem[11] = '{opc: ADD,  op_a: 1,  op_b: 1};
    res_ready = 1'b0; first_ptr = 10; count = 6'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", res_valid, 1);
      check("stall_result", result, -12);
      check("stall_read_pointer", read_pointer, 10);
      start     = (i == 2);
      first_ptr = 20;
      @(negedge clk);
    end
    start = 1'b0;
    check("stall_still_valid", res_valid, 1);
    res_ready = 1'b1;
    @(negedge clk);
    check("stall_ptr_advanced", read_pointer, 11);
    check("stall_valid_low", res_valid, 0);
    n = 0;
    while (!res_valid && n < 10) begin @(negedge clk); n++; end
    check("stall_second_result", result, 2);
    check("stall_second_index", res_index, 11);
    @(negedge clk);
    check("stall_done", done, 1);

    // ---------------- reset during EXEC of second entry ----------------
    mem[5] = '{opc: ADD,  op_a: 2, op_b: 3};
    mem[6] = '{opc: SUB,  op_a: 2, op_b: 3};
    mem[7] = '{opc: MULT, op_a: 2, op_b: 3};
    res_ready = 1'b1; first_ptr = 5; count = 6'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;                       // N+1
    repeat (2) @(negedge clk);                          // N+3 first result
    check("rst_first_result", result, 5);
    repeat (2) @(negedge clk);                          // N+5 EXEC second
    check("rst_in_exec", {busy, res_valid}, 2'b10);
    reset = 1'b1;
    #1;
    check("rst_async_outputs",
          {read_pointer, res_valid, result, res_opcode, res_index, div_by_zero, busy, done},
          '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    count = 6'd0; first_ptr = 3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("zero_run_done", {done, busy, res_valid}, 3'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_run_quiet", {done, busy, res_valid}, 3'b000);
    end

    // ---------------- randomized runs against the model ----------------
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem[i].opc  = opcode_t'(4'($urandom_range(0, 15)));
        mem[i].op_a = rand_operand();
        mem[i].op_b = rand_operand();
      end
      do_run(int'($urandom_range(0, 31)), int'($urandom_range(0, 9)),
             int'($urandom_range(30, 100)));
    end

    // Count above the depth clamps to a full 32-entry pass.
    do_run(17, 40, 80);
    check("clamp_count", obs_res.size(), 32);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_exec.md
# instr_exec

Consumer at the read side of the instruction register. On a start command it walks `read_pointer` across a run of entries, captures each `instruction_word`, executes the opcode on the operands, and returns one result per instruction over a valid/ready handshake. It sits beside `instr_register` in the DUT, on the read port that the testbench currently drives.

## Interface
- `NUM_ENTRIES`, 32: register depth. Must be a power of two; pointer width is log2(NUM_ENTRIES).
- `RES_W`, 64: result width, signed.
- `clk`, input, 1: the only clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: single-cycle run request; sampled only in IDLE.
- `first_ptr`, input, address_t: first entry of the run.
- `count`, input, 6: number of entries to execute, 0..32.
- `read_pointer`, output, address_t: address presented to `instr_register`.
- `instruction_word`, input, instruction_t: combinational read data from `instr_register`.
- `res_valid`, output, 1: `result` and its tags are valid.
- `res_ready`, input, 1: downstream accepts the result.
- `result`, output, RES_W: signed execution result.
- `res_opcode`, output, opcode_t: opcode that produced `result`.
- `res_index`, output, address_t: entry that produced `result`.
- `div_by_zero`, output, 1: flag qualifying `result`; set for DIV or MOD with op_b == 0.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when a run completes.

## Operation
- States:
  - IDLE: waits for a run request.
  - FETCH: drives `read_pointer` = ptr and registers `instruction_word` and ptr at the end of the cycle.
  - EXEC: computes the result and registers it together with the tags.
  - HOLD: `res_valid` = 1 while waiting for the handshake.
- IDLE with `start` = 1 and `count` != 0: latch ptr = `first_ptr`, remaining = `count` (values above 32 clamp to 32), go to FETCH.
- IDLE with `start` = 1 and `count` == 0: stay in IDLE and pulse `done` in the next cycle.
- `start` in any state other than IDLE is ignored.
- HOLD with `res_ready` = 1 (handshake):
  - ptr increments modulo NUM_ENTRIES, so 31 wraps to 0.
  - remaining decrements.
  - If remaining reaches 0: go to IDLE and pulse `done` in the following cycle. Otherwise go to FETCH.
- HOLD with `res_ready` = 0: `result`, `res_opcode`, `res_index` and `div_by_zero` hold stable. `res_valid` never drops without a handshake, except on reset.
- Arithmetic: operands are signed 32-bit, sign-extended to RES_W before the operation.
  - ZERO: 0.
  - PASSA: op_a.
  - PASSB: op_b.
  - ADD: a+b.
  - SUB: a−b.
  - MULT: full 64-bit product.
  - DIV: truncates toward zero.
  - MOD: sign follows the dividend.
  - DIV or MOD with b == 0: result 0 and `div_by_zero` = 1.
  - Any undefined opcode encoding: result 0.
- Reset, including mid-run: asserting `reset` returns to IDLE immediately. All outputs go to 0 asynchronously: `read_pointer`, `res_valid`, `result`, `res_opcode` (ZERO), `res_index`, `div_by_zero`, `busy` and `done`. A partially executed run is abandoned.

## Timing
- `start` sampled in cycle N, then FETCH in N+1, EXEC in N+2, and `res_valid` first high in N+3.
- With `res_ready` held high, each subsequent result arrives 3 cycles after the previous handshake.
- A handshake in cycle M on the last entry produces `done` = 1 in M+1, with `busy` = 0 and `res_valid` = 0 in that same cycle. A new `start` is accepted from M+1.
- `read_pointer` changes only on entry to FETCH and holds through EXEC and HOLD.

## Structure
- `instr_register_pkg` owns the shared types: opcode_t, operand_t, address_t, instruction_t, plus a new `result_t` (signed [63:0]).
- One combinational sub-module, `instr_alu`: takes instruction_t and returns result_t and the divide-by-zero flag.
- The FSM, pointer counter and output registers stay in `instr_exec`.

## Test plan
- Write ADD 5,7 at entry 0, then `start` with `first_ptr`=0 and `count`=1 while `res_ready` is high → `result`=12, `res_index`=0 in N+3; `done` in N+4.
- Write DIV 9,0 and MOD −7,3 at entries 3–4, then run from 3 with count 2 → results 0 with `div_by_zero`=1, then −1 with `div_by_zero`=0.
- Run with `first_ptr`=30 and `count`=4 → `res_index` sequence 30, 31, 0, 1.
- Hold `res_ready` low for 5 cycles on the first result of MULT −3,4 → `result`=−12 held stable with `res_valid` high; after the handshake, `read_pointer` advances.
- Assert `reset` during EXEC of the second entry in a 3-entry run → all outputs 0 immediately. A new run of `count`=0 then yields only a `done` pulse, with no `res_valid`.
